change_dispenser: RTL and testbench

//  Downstream of the vending controller (UUT). On a Return request, pays out the

---
 rtl/vend_pkg.sv | 26 ++
 rtl/denom_picker.sv | 42 ++++
 rtl/change_dispenser.sv | 150 +++++++++++++++
 tb/tb_change_dispenser.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the change dispenser.
// Coin weights are expressed in 50-won units.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        D50,
        D100,
        D500,
        D1000
    } denom_t;

    localparam int W50   = 1;
    localparam int W100  = 2;
    localparam int W500  = 10;
    localparam int W1000 = 20;

endpackage

// File: rtl/denom_picker.sv
// Chooses the largest coin that fits the unpaid amount and is still stocked.
// Purely combinational; the FSM decides when the result is used.
module denom_picker
    import vend_pkg::*;
#(
    parameter int AMT_W = 7
) (
    input  logic [AMT_W-1:0] remain,
    input  logic             empty50,
    input  logic             empty100,
    input  logic             empty500,
    input  logic             empty1000,
    output logic             valid,
    output denom_t           denom,
    output logic [AMT_W-1:0] weight
);

    // Priority order runs from largest to smallest coin.
    always_comb begin
        valid  = 1'b0;
        denom  = D50;
        weight = '0;
        if (!empty1000 && remain >= AMT_W'(W1000)) begin
            valid  = 1'b1;
            denom  = D1000;
            weight = AMT_W'(W1000);
        end else if (!empty500 && remain >= AMT_W'(W500)) begin
            valid  = 1'b1;
            denom  = D500;
            weight = AMT_W'(W500);
        end else if (!empty100 && remain >= AMT_W'(W100)) begin
            valid  = 1'b1;
            denom  = D100;
            weight = AMT_W'(W100);
        end else if (!empty50 && remain >= AMT_W'(W50)) begin
            valid  = 1'b1;
            denom  = D50;
            weight = AMT_W'(W50);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out the controller balance one coin at a time, largest first,
// waiting for the hopper's acknowledge after each request.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Return,
    input  logic [AMT_W-1:0] Amount,
    input  logic             Empty50,
    input  logic             Empty100,
    input  logic             Empty500,
    input  logic             Empty1000,
    input  logic             HopperAck,
    output logic             Return50,
    output logic             Return100,
    output logic             Return500,
    output logic             Return1000,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic [AMT_W-1:0] Remain
);

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    state_t           state, next_state;
    logic [AMT_W-1:0] remain_q;
    denom_t           denom_q;
    logic [AMT_W-1:0] weight_q;
    logic [TW-1:0]    timer_q;

    logic             pick_valid;
    denom_t           pick_denom;
    logic [AMT_W-1:0] pick_weight;

    logic load_amount, latch_pick, pay_coin, timer_clr, timer_inc;

    denom_picker #(.AMT_W(AMT_W)) u_picker (
        .remain    (remain_q),
        .empty50   (Empty50),
        .empty100  (Empty100),
        .empty500  (Empty500),
        .empty1000 (Empty1000),
        .valid     (pick_valid),
        .denom     (pick_denom),
        .weight    (pick_weight)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    // Empty flags only matter in SELECT; the chosen coin is latched for ISSUE/WAIT.
    always_comb begin
        next_state  = state;
        load_amount = 1'b0;
        latch_pick  = 1'b0;
        pay_coin    = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        Fault       = 1'b0;
        Return50    = 1'b0;
        Return100   = 1'b0;
        Return500   = 1'b0;
        Return1000  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Return) begin
                    if (Amount != '0) begin
                        load_amount = 1'b1;
                        next_state  = S_SELECT;
                    end else begin
                        next_state  = S_DONE;
                    end
                end
            end
            S_SELECT: begin
                Busy = 1'b1;
                if (remain_q == '0) begin
                    next_state = S_DONE;
                end else if (pick_valid) begin
                    latch_pick = 1'b1;
                    next_state = S_ISSUE;
                end else begin
                    next_state = S_FAULT;
                end
            end
            S_ISSUE: begin
                Busy      = 1'b1;
                timer_clr = 1'b1;
                case (denom_q)
                    D50:     Return50   = 1'b1;
                    D100:    Return100  = 1'b1;
                    D500:    Return500  = 1'b1;
                    D1000:   Return1000 = 1'b1;
                    default: Return50   = 1'b0;
                endcase
                next_state = S_WAIT;
            end
            S_WAIT: begin
                Busy = 1'b1;
                if (HopperAck) begin
                    pay_coin   = 1'b1;
                    next_state = S_SELECT;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    next_state = S_FAULT;
                end else begin
                    timer_inc  = 1'b1;
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                next_state = S_IDLE;
            end
            S_FAULT: begin
                Fault = 1'b1;
                if (Return) next_state = S_SELECT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            remain_q <= '0;
            denom_q  <= D50;
            weight_q <= '0;
            timer_q  <= '0;
        end else begin
            if (load_amount)   remain_q <= Amount;
            else if (pay_coin) remain_q <= remain_q - weight_q;
            if (latch_pick) begin
                denom_q  <= pick_denom;
                weight_q <= pick_weight;
            end
            if (timer_clr)      timer_q <= '0;
            else if (timer_inc) timer_q <= timer_q + 1'b1;
        end
    end

    assign Remain = remain_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin/Done/Fault events are
// queued by the stimulus and consumed by an independent monitor.
module tb_change_dispenser;

    localparam int AMT_W       = 7;
    localparam int ACK_TIMEOUT = 15;
    localparam int EV_DONE     = 4;
    localparam int EV_FAULT    = 5;

    logic             CLK = 1'b0;
    logic             RST;
    logic             Return;
    logic [AMT_W-1:0] Amount;
    logic             Empty50, Empty100, Empty500, Empty1000;
    logic             HopperAck;
    logic             Return50, Return100, Return500, Return1000;
    logic             Busy, Done, Fault;
    logic [AMT_W-1:0] Remain;

    int  total = 0;
    int  bad   = 0;
    int  exp_q[$];
    bit  ack_en    = 1'b1;
    int  ack_delay = 2;
    bit  prev_fault = 1'b0;

    change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Return     (Return),
        .Amount     (Amount),
        .Empty50    (Empty50),
        .Empty100   (Empty100),
        .Empty500   (Empty500),
        .Empty1000  (Empty1000),
        .HopperAck  (HopperAck),
        .Return50   (Return50),
        .Return100  (Return100),
        .Return500  (Return500),
        .Return1000 (Return1000),
        .Busy       (Busy),
        .Done       (Done),
        .Fault      (Fault),
        .Remain     (Remain)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic int coin_code();
        if (Return50)   return 0;
        if (Return100)  return 1;
        if (Return500)  return 2;
        if (Return1000) return 3;
        return -1;
    endfunction

    function automatic int n_returns();
        return int'(Return50) + int'(Return100) + int'(Return500) + int'(Return1000);
    endfunction

    task automatic pop_check(input string name, input int code);
        int e;
        if (exp_q.size() == 0) begin
            check_output({name, " unexpected"}, code, -1);
        end else begin
            e = exp_q.pop_front();
            check_output(name, code, e);
        end
    endtask

    // Monitor: every visible coin pulse, Done pulse or Fault rise consumes one entry
    initial begin
        int code;
        forever begin
            @(negedge CLK);
            if (n_returns() > 1) check_output("one-hot returns", n_returns(), 1);
            code = coin_code();
            if (code >= 0) pop_check("coin", code);
            if (Done) pop_check("done", EV_DONE);
            if (Fault && !prev_fault) pop_check("fault", EV_FAULT);
            prev_fault = Fault;
        end
    end

    // Hopper model: acknowledges each request ack_delay cycles later when enabled
    initial begin
        HopperAck = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_en && (Return50 || Return100 || Return500 || Return1000)) begin
                repeat (ack_delay) @(negedge CLK);
                HopperAck = 1'b1;
                @(negedge CLK);
                HopperAck = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input int amt);
        Return = 1'b1;
        Amount = AMT_W'(amt);
        @(negedge CLK);
        Return = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !Done; i++) @(negedge CLK);
        check_output({name, " done seen"}, int'(Done), 1);
    endtask

    task automatic wait_fault(input string name, input int budget);
        for (int i = 0; i < budget && !Fault; i++) @(negedge CLK);
        check_output({name, " fault seen"}, int'(Fault), 1);
    endtask

    task automatic wait_coin(input string name, input int code, input int budget);
        for (int i = 0; i < budget && coin_code() != code; i++) @(negedge CLK);
        check_output({name, " coin seen"}, coin_code(), code);
    endtask

    initial begin
        int n;
        RST = 1'b1; Return = 1'b0; Amount = '0;
        Empty50 = 1'b0; Empty100 = 1'b0; Empty500 = 1'b0; Empty1000 = 1'b0;
        repeat (3) @(negedge CLK);
        check_output("reset busy", int'(Busy), 0);
        check_output("reset done", int'(Done), 0);
        check_output("reset fault", int'(Fault), 0);
        check_output("reset remain", int'(Remain), 0);
        check_output("reset returns", n_returns(), 0);
        RST = 1'b0;
        @(negedge CLK);

        // 7 units: three 100s then one 50
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
        exp_q.push_back(0); exp_q.push_back(EV_DONE);
        apply_stimulus(7);
        check_output("t1 busy start", int'(Busy), 1);
        wait_done("t1", 200);
        check_output("t1 remain", int'(Remain), 0);
        check_output("t1 busy at done", int'(Busy), 0);
        @(negedge CLK);
        check_output("t1 done one pulse", int'(Done), 0);
        check_output("t1 busy after", int'(Busy), 0);

        // 30 units with 1000 empty: three 500s
        Empty1000 = 1'b1;
        exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(EV_DONE);
        apply_stimulus(30);
        wait_done("t2", 200);
        check_output("t2 remain", int'(Remain), 0);
        Empty1000 = 1'b0;
        @(negedge CLK);

        // 3 units with 100 empty: three 50s
        Empty100 = 1'b1;
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(EV_DONE);
        apply_stimulus(3);
        wait_done("t2b", 200);
        Empty100 = 1'b0;
        @(negedge CLK);

        // 1 unit with 50 empty: fault, then retry (Amount ignored) pays one 50
        Empty50 = 1'b1;
        exp_q.push_back(EV_FAULT);
        apply_stimulus(1);
        wait_fault("t3", 20);
        check_output("t3 remain", int'(Remain), 1);
        check_output("t3 busy", int'(Busy), 0);
        repeat (3) @(negedge CLK);
        check_output("t3 fault sticky", int'(Fault), 1);
        Empty50 = 1'b0;
        exp_q.push_back(0); exp_q.push_back(EV_DONE);
        apply_stimulus(5);
        check_output("t3 retry busy", int'(Busy), 1);
        wait_done("t3 retry", 200);
        check_output("t3 fault cleared", int'(Fault), 0);
        check_output("t3 remain after", int'(Remain), 0);
        @(negedge CLK);

        // 20 units, hopper silent: timeout fault, then retry with acks
        ack_en = 1'b0;
        exp_q.push_back(3); exp_q.push_back(EV_FAULT);
        apply_stimulus(20);
        wait_coin("t4", 3, 20);
        n = 0;
        while (!Fault && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check_output("t4 timeout cycles", n, ACK_TIMEOUT + 1);
        check_output("t4 remain", int'(Remain), 20);
        ack_en = 1'b1;
        exp_q.push_back(3); exp_q.push_back(EV_DONE);
        apply_stimulus(7);
        wait_done("t4 retry", 200);
        check_output("t4 remain after", int'(Remain), 0);
        @(negedge CLK);

        // Zero amount: immediate Done, never busy
        exp_q.push_back(EV_DONE);
        apply_stimulus(0);
        check_output("t5 busy", int'(Busy), 0);
        wait_done("t5", 5);
        @(negedge CLK);
        check_output("t5 done one pulse", int'(Done), 0);
        check_output("t5 busy after", int'(Busy), 0);

        // Reset while waiting for ack; the late ack must be ignored
        ack_delay = 6;
        exp_q.push_back(1);
        apply_stimulus(2);
        wait_coin("t6", 1, 20);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_output("t6 busy", int'(Busy), 0);
        check_output("t6 remain", int'(Remain), 0);
        check_output("t6 returns", n_returns(), 0);
        check_output("t6 fault", int'(Fault), 0);
        repeat (10) @(negedge CLK);
        check_output("t6 busy late", int'(Busy), 0);
        check_output("t6 remain late", int'(Remain), 0);
        ack_delay = 2;

        check_output("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
